// File: rtl/mips_run_ctrl.sv
// Reset and run-control sequencer for the MIPS core: reset hold, run gating, budget/self-loop/abort stop.
// Optional MIPS_RUN_TRACE_EN adds simulation-only per-cycle trace output; logic is unchanged.
module mips_run_ctrl #(
  parameter int unsigned PC_W          = 32,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned RST_CYCLES    = 1,
  parameter int unsigned IFU_RST_EXTRA = 0,
  parameter int unsigned MAX_CYCLES    = 48,
  parameter int unsigned STALL_LIMIT   = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             core_Reset,
  output logic             ifu_Reset,
  output logic             run,
  output logic             done,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned RST_TOTAL = RST_CYCLES + IFU_RST_EXTRA;
  localparam int unsigned RC_W      = (RST_TOTAL > 1) ? $clog2(RST_TOTAL) : 1;
  localparam int unsigned SC_W      = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

  localparam logic [RC_W-1:0]  RST_LAST    = RC_W'(RST_TOTAL - 1);
  localparam logic [SC_W-1:0]  SAME_LAST   = SC_W'((STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0);
  localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [RC_W-1:0]  rst_cnt;
  logic [PC_W-1:0]  prev_pc;
  logic             prev_pc_vld;
  logic [SC_W-1:0]  same_cnt;

  logic             pc_repeat;
  logic             loop_hit;
  logic             budget_hit;
  logic [1:0]       exit_cause;
  logic             run_exit;
  logic [CNT_W-1:0] cnt_next;
  logic             core_rst_next;

  always_comb begin
    pc_repeat     = pc_valid && prev_pc_vld && (pc == prev_pc);
    loop_hit      = (STALL_LIMIT != 0) && pc_repeat && (same_cnt == SAME_LAST);
    budget_hit    = (MAX_CYCLES != 0) && (cycle_cnt == BUDGET_LAST);
    exit_cause    = abort      ? 2'b11 :
                    loop_hit   ? 2'b10 :
                    budget_hit ? 2'b01 : 2'b00;
    run_exit      = (state == S_RUN) && (exit_cause != 2'b00);
    cnt_next      = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    // core_Reset is registered, so it is computed for the RST cycle about to start
    core_rst_next = (32'(rst_cnt) + 32'd1) < RST_CYCLES;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      core_Reset  <= 1'b1;
      ifu_Reset   <= 1'b1;
      run         <= 1'b0;
      done        <= 1'b0;
      halt_cause  <= 2'b00;
      cycle_cnt   <= '0;
      rst_cnt     <= '0;
      prev_pc     <= '0;
      prev_pc_vld <= 1'b0;
      same_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RST;
            rst_cnt    <= '0;
            cycle_cnt  <= '0;
            core_Reset <= 1'b1;
            ifu_Reset  <= 1'b1;
          end
        end
        S_RST: begin
          if (rst_cnt == RST_LAST) begin
            state       <= S_RUN;
            core_Reset  <= 1'b0;
            ifu_Reset   <= 1'b0;
            run         <= 1'b1;
            prev_pc_vld <= 1'b0;
            same_cnt    <= '0;
          end else begin
            rst_cnt    <= rst_cnt + RC_W'(1);
            core_Reset <= core_rst_next;
          end
        end
        S_RUN: begin
          cycle_cnt <= cnt_next;
          if (pc_valid) begin
            prev_pc     <= pc;
            prev_pc_vld <= 1'b1;
            same_cnt    <= pc_repeat ? same_cnt + SC_W'(1) : '0;
          end
          if (run_exit) begin
            state      <= S_DONE;
            run        <= 1'b0;
            done       <= 1'b1;
            halt_cause <= exit_cause;
          end
        end
        S_DONE: begin
          if (start) begin
            state      <= S_RST;
            rst_cnt    <= '0;
            cycle_cnt  <= '0;
            done       <= 1'b0;
            halt_cause <= 2'b00;
            core_Reset <= 1'b1;
            ifu_Reset  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MIPS_RUN_TRACE_EN
  always_ff @(posedge Clk) begin
    if (!Reset && state == S_RUN) begin
      $display("mips_run_ctrl: cycle %0d pc %h", cycle_cnt, pc);
      if (run_exit)
        $display("mips_run_ctrl: done cause %b cycles %0d", exit_cause, cnt_next);
    end
  end
`else
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed self-checking bench for mips_run_ctrl: three parameterisations share one stimulus stream.
module tb_mips_run_ctrl;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic        abort;
  logic [31:0] pc;
  logic        pc_valid;

  logic        d_core, d_ifu, d_run, d_done;
  logic [1:0]  d_halt;
  logic [15:0] d_cnt;
  logic        r_core, r_ifu, r_run, r_done;
  logic [1:0]  r_halt;
  logic [15:0] r_cnt;
  logic        u_core, u_ifu, u_run, u_done;
  logic [1:0]  u_halt;
  logic [3:0]  u_cnt;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned runs;

  mips_run_ctrl u_def (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort), .pc(pc), .pc_valid(pc_valid),
    .core_Reset(d_core), .ifu_Reset(d_ifu), .run(d_run), .done(d_done),
    .halt_cause(d_halt), .cycle_cnt(d_cnt)
  );

  mips_run_ctrl #(.RST_CYCLES(2), .IFU_RST_EXTRA(3)) u_rst (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort), .pc(pc), .pc_valid(pc_valid),
    .core_Reset(r_core), .ifu_Reset(r_ifu), .run(r_run), .done(r_done),
    .halt_cause(r_halt), .cycle_cnt(r_cnt)
  );

  mips_run_ctrl #(.CNT_W(4), .MAX_CYCLES(0), .STALL_LIMIT(0)) u_unl (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort), .pc(pc), .pc_valid(pc_valid),
    .core_Reset(u_core), .ifu_Reset(u_ifu), .run(u_run), .done(u_done),
    .halt_cause(u_halt), .cycle_cnt(u_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    runs     = 0;
    Reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    pc       = '0;
    pc_valid = 1'b0;

    // reset state
    tick();
    chk("rst_core", d_core, 1);
    chk("rst_ifu", d_ifu, 1);
    chk("rst_run", d_run, 0);
    chk("rst_done", d_done, 0);
    chk("rst_halt", d_halt, 0);
    chk("rst_cnt", d_cnt, 0);
    chk("rst_u_run", u_run, 0);
    Reset = 1'b0;
    tick();
    chk("idle_core", d_core, 1);
    chk("idle_run", d_run, 0);

    // default run to budget; u_rst shows stretched reset timing
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("A_rst_core", d_core, 1);
    chk("A_rst_ifu", d_ifu, 1);
    chk("A_rst_run", d_run, 0);
    chk("R_k0_core", r_core, 1);
    tick();
    chk("A_run_core", d_core, 0);
    chk("A_run_ifu", d_ifu, 0);
    chk("A_run_run", d_run, 1);
    chk("A_run_cnt0", d_cnt, 0);
    chk("R_k1_core", r_core, 1);
    chk("R_k1_ifu", r_ifu, 1);
    tick();
    chk("A_cnt1", d_cnt, 1);
    chk("R_k2_core", r_core, 0);
    chk("R_k2_ifu", r_ifu, 1);
    tick();
    tick();
    chk("R_k4_ifu", r_ifu, 1);
    chk("R_k4_run", r_run, 0);
    tick();
    chk("R_k5_ifu", r_ifu, 0);
    chk("R_k5_run", r_run, 1);
    chk("R_k5_cnt", r_cnt, 0);
    chk("A_cnt4", d_cnt, 4);
    for (int i = 0; i < 42; i++) begin
      tick();
      if (d_run) runs++;
    end
    chk("A_run_len", runs, 42);
    tick();
    chk("A_last_cnt", d_cnt, 47);
    chk("A_last_run", d_run, 1);
    chk("A_last_done", d_done, 0);
    tick();
    chk("A_done", d_done, 1);
    chk("A_done_run", d_run, 0);
    chk("A_halt", d_halt, 2'b01);
    chk("A_cnt48", d_cnt, 48);
    for (int i = 0; i < 6; i++) tick();
    chk("A_frozen_cnt", d_cnt, 48);
    chk("A_done_core", d_core, 0);
    chk("A_done_ifu", d_ifu, 0);
    chk("R_done", r_done, 1);
    chk("R_halt", r_halt, 2'b01);
    chk("R_cnt48", r_cnt, 48);
    chk("U_sat_cnt", u_cnt, 15);
    chk("U_sat_run", u_run, 1);
    chk("U_sat_done", u_done, 0);

    // self-loop, contiguous samples
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("B_restart_done", d_done, 0);
    chk("B_restart_halt", d_halt, 0);
    chk("B_restart_cnt", d_cnt, 0);
    chk("B_restart_core", d_core, 1);
    tick();
    pc_valid = 1'b1;
    pc = 32'h0;  tick();
    pc = 32'h4;  tick();
    pc = 32'h8;  tick();
    tick();
    tick();
    tick();
    chk("B_pre_done", d_done, 0);
    chk("B_pre_run", d_run, 1);
    tick();
    chk("B_done", d_done, 1);
    chk("B_halt", d_halt, 2'b10);
    chk("B_cnt", d_cnt, 7);
    chk("U_noloop_run", u_run, 1);
    chk("U_noloop_done", u_done, 0);

    // self-loop with invalid-sample gaps
    pc_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pc_valid = 1'b1; pc = 32'h0;  tick();
    pc = 32'h4;                    tick();
    pc = 32'h8;                    tick();
    pc_valid = 1'b0; pc = 32'h1c;  tick();
    pc_valid = 1'b1; pc = 32'h8;   tick();
    pc_valid = 1'b0; pc = 32'h1c;  tick();
    pc_valid = 1'b1; pc = 32'h8;   tick();
    tick();
    chk("C_pre_done", d_done, 0);
    tick();
    chk("C_done", d_done, 1);
    chk("C_halt", d_halt, 2'b10);
    chk("C_cnt", d_cnt, 9);

    // abort coinciding with budget exhaustion
    pc_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("D_run", d_run, 1);
    chk("D_cnt0", d_cnt, 0);
    chk("D_halt_clr", d_halt, 0);
    for (int i = 0; i < 47; i++) tick();
    chk("D_cnt47", d_cnt, 47);
    abort = 1'b1;
    tick();
    chk("D_done", d_done, 1);
    chk("D_halt", d_halt, 2'b11);
    chk("D_cnt48", d_cnt, 48);
    chk("U_abort_done", u_done, 1);
    chk("U_abort_halt", u_halt, 2'b11);
    chk("U_abort_run", u_run, 0);
    chk("U_abort_cnt", u_cnt, 15);
    tick();
    abort = 1'b0;
    chk("D_abort_ign_halt", d_halt, 2'b11);
    chk("D_abort_ign_cnt", d_cnt, 48);

    // restart, start ignored while running, then reset mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("E_done_clr", d_done, 0);
    chk("E_cnt_clr", d_cnt, 0);
    chk("E_halt_clr", d_halt, 0);
    tick();
    chk("E_run", d_run, 1);
    chk("E_cnt0", d_cnt, 0);
    tick();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("E_start_ign_cnt", d_cnt, 4);
    chk("E_start_ign_ifu", d_ifu, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("E_cnt10", d_cnt, 10);
    Reset = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    Reset = 1'b0;
    start = 1'b0;
    chk("F_core", d_core, 1);
    chk("F_ifu", d_ifu, 1);
    chk("F_run", d_run, 0);
    chk("F_cnt", d_cnt, 0);
    chk("F_done", d_done, 0);
    chk("F_halt", d_halt, 0);
    tick();
    abort = 1'b0;
    chk("F_idle_abort_core", d_core, 1);
    chk("F_idle_abort_done", d_done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("G_run", d_run, 1);
    chk("G_cnt", d_cnt, 0);
    chk("G_core", d_core, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Synthesizable reset and run-control sequencer for the MIPS core. It generates the core reset and the IFU reset with configurable hold lengths, then gates execution with `run`. It counts run cycles and stops the run on a cycle budget, on a detected self-loop (PC stuck), or on abort, and reports the cause. It sits between the top-level clock/reset and the core, replacing a hand-written fixed reset/run sequence.

Parameters:
- PC_W, 32, PC width.
- CNT_W, 16, cycle counter width.
- RST_CYCLES, 1, cycles core_Reset is held in RST (must be >=1).
- IFU_RST_EXTRA, 0, extra cycles ifu_Reset stays high after core_Reset drops.
- MAX_CYCLES, 48, run-cycle budget; 0 = unlimited.
- STALL_LIMIT, 4, consecutive repeated valid PCs that count as halt; 0 = detection off.

Ports:
- Clk, in, 1, clock, rising edge.
- Reset, in, 1, synchronous active-high reset.
- start, in, 1, begin a run (single-cycle pulse or level).
- abort, in, 1, force end of run.
- pc, in, PC_W, current core PC.
- pc_valid, in, 1, pc sample valid this cycle.
- core_Reset, out, 1, reset to the core datapath.
- ifu_Reset, out, 1, reset to the IFU.
- run, out, 1, core clock enable.
- done, out, 1, run finished.
- halt_cause, out, 2, 00 none, 01 budget, 10 self-loop, 11 abort.
- cycle_cnt, out, CNT_W, RUN cycles elapsed.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named `Clk` and `Reset`.
- Reset values: state=IDLE, core_Reset=1, ifu_Reset=1, run=0, done=0, halt_cause=00, cycle_cnt=0.
- State IDLE: both resets high, run=0. When `start` is high at an edge, the block moves to RST, clears rst_cnt and clears cycle_cnt.
- State RST: lasts RST_CYCLES+IFU_RST_EXTRA cycles.
  - core_Reset=1 while rst_cnt<RST_CYCLES, else 0.
  - ifu_Reset=1 for the whole of RST.
  - Next state is RUN.
  - Example: with defaults, start sampled at edge k gives RST during cycle k+1 and RUN from k+2.
- State RUN: both resets low, run=1.
  - cycle_cnt is 0 in the first RUN cycle and increments by 1 per cycle.
  - With MAX_CYCLES=0, cycle_cnt saturates at all-ones and never wraps.
- Self-loop detector:
  - prev_pc_vld is cleared on RUN entry.
  - On a cycle with pc_valid and prev_pc_vld, when pc==prev_pc, same_cnt increments; when pc differs, same_cnt=0.
  - prev_pc and prev_pc_vld load on every pc_valid.
  - pc_valid=0 leaves prev_pc and same_cnt unchanged.
- Exit conditions from RUN, evaluated per cycle, with priority abort > self-loop > budget:
  - abort=1 ends the run with cause 11.
  - same_cnt reaching STALL_LIMIT-1 with a further matching PC ends the run with cause 10.
  - cycle_cnt==MAX_CYCLES-1 ends the run with cause 01. RUN therefore lasts exactly MAX_CYCLES cycles, and cycle_cnt reads MAX_CYCLES in DONE.
  - The exit takes effect at the next edge: state=DONE and halt_cause latched.
- State DONE: run=0, done=1, resets stay low so core state stays observable, halt_cause and cycle_cnt are frozen.
  - start in DONE restarts: go to RST, clear done, halt_cause and cycle_cnt.
- Ignored inputs:
  - start in RST or RUN is ignored.
  - abort in IDLE, RST or DONE is ignored.
- Reset mid-operation, in any state: at the next edge all outputs return to their reset values. Reset has priority over start and abort in the same cycle.
- Width rule: CNT_W must represent MAX_CYCLES. Any comparison between cycle_cnt and MAX_CYCLES is done at CNT_W bits.

Optional Feature:
- Macro: MIPS_RUN_TRACE_EN.
- Defined: simulation-only $display every RUN cycle printing cycle_cnt and pc, plus one line on DONE entry with halt_cause and cycle_cnt.
- Undefined: no display code is present. Logic and timing are identical in both cases.

Test Plan:
- Defaults; Reset 1 cycle, start at cycle 2:
  - core_Reset and ifu_Reset are 1 through the RST cycle, 0 from the next.
  - run=1 for exactly 48 cycles.
  - Then done=1, halt_cause=01, cycle_cnt=48.
- RST_CYCLES=2, IFU_RST_EXTRA=3: core_Reset is high for 2 RST cycles, ifu_Reset for 5 RST cycles, and run rises on the 6th cycle after start.
- Self-loop: pc_valid=1 with pc sequence 0x0,0x4,0x8,0x8,0x8,0x8,0x8 → done on the edge after the 4th consecutive repeated valid PC sample, i.e. the pc_valid=1, pc==prev_pc condition; halt_cause=10.
  - Repeat with pc_valid=0 gaps between the 0x8 samples → same result, delayed by the number of gaps.
- abort and budget limit in the same cycle → halt_cause=11.
  - A following start → new run with cycle_cnt=0 and done=0.
- Reset asserted mid-RUN (cycle_cnt=10) → next edge: IDLE, core_Reset=ifu_Reset=1, run=0, cycle_cnt=0; start then re-runs normally.
- MAX_CYCLES=0, STALL_LIMIT=0, CNT_W=4: run stays 1, cycle_cnt saturates at 15, and only abort ends the run (cause 11).
